// File: rtl/an_encoder_28bits_pkg.sv
// rtl/an_encoder_28bits_pkg.sv - shared AN-code constants and encoder state enum (AN_ERR_INJECT_EN adds ST_INJ)
package an_code_pkg;

   localparam int A            = 17619;
   localparam int A_BITS       = 15;
   localparam int N_BITS       = 28;
   localparam int W_BITS       = 44;
   localparam int CNT_BITS     = 4;
   localparam int ERR_POS_BITS = 6;

   localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
`ifdef AN_ERR_INJECT_EN
      ST_INJ  = 2'd2,
`endif
      ST_OUT  = 2'd3
   } enc_state_e;

endpackage

// File: rtl/an_encoder_28bits_if.sv
// rtl/an_encoder_28bits_if.sv - encoder handshake bundle; err_* fields exist only with AN_ERR_INJECT_EN
interface an_encoder_28bits_if;
   import an_code_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [N_BITS-1:0] N;
   logic              out_valid;
   logic              out_ready;
   logic [W_BITS-1:0] W;
`ifdef AN_ERR_INJECT_EN
   logic                    err_en;
   logic                    err_sign;
   logic [ERR_POS_BITS-1:0] err_pos;
`endif

   modport master (
`ifdef AN_ERR_INJECT_EN
      output err_en, err_pos, err_sign,
`endif
      output in_valid, N, out_ready,
      input  in_ready, out_valid, W
   );

   modport slave (
`ifdef AN_ERR_INJECT_EN
      input  err_en, err_pos, err_sign,
`endif
      input  in_valid, N, out_ready,
      output in_ready, out_valid, W
   );

endinterface

// File: rtl/an_encoder_28bits_err_inject.sv
// rtl/an_encoder_28bits_err_inject.sv - combinational +/-2^pos error injector, built only with AN_ERR_INJECT_EN
`ifdef AN_ERR_INJECT_EN
module an_err_inject
   import an_code_pkg::*;
(
   input  logic [W_BITS-1:0]       acc_i,
   input  logic                    err_en_i,
   input  logic [ERR_POS_BITS-1:0] err_pos_i,
   input  logic                    err_sign_i,
   output logic [W_BITS-1:0]       acc_o
);

   logic [W_BITS-1:0] delta;

   // Positions beyond the codeword leave the word untouched rather than aliasing.
   always_comb begin
      delta = '0;
      if (err_en_i && (err_pos_i < ERR_POS_BITS'(W_BITS))) begin
         delta = W_BITS'(1) << err_pos_i;
      end
      acc_o = err_sign_i ? (acc_i - delta) : (acc_i + delta);
   end

endmodule
`endif

// File: rtl/an_encoder_28bits.sv
// rtl/an_encoder_28bits.sv - sequential shift-and-add AN encoder W = A*N; AN_ERR_INJECT_EN adds an INJ step
module an_encoder_28bits
   import an_code_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   an_encoder_28bits_if.slave  bus
);

   enc_state_e          state_q, state_d;
   logic [W_BITS-1:0]   mcand_q, mcand_d;
   logic [W_BITS-1:0]   acc_q,   acc_d;
   logic [CNT_BITS-1:0] cnt_q,   cnt_d;

`ifdef AN_ERR_INJECT_EN
   logic                    err_en_q,   err_en_d;
   logic                    err_sign_q, err_sign_d;
   logic [ERR_POS_BITS-1:0] err_pos_q,  err_pos_d;
   logic [W_BITS-1:0]       inj_acc;

   an_err_inject u_err_inject (
      .acc_i      (acc_q),
      .err_en_i   (err_en_q),
      .err_pos_i  (err_pos_q),
      .err_sign_i (err_sign_q),
      .acc_o      (inj_acc)
   );
`endif

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifdef AN_ERR_INJECT_EN
      err_en_d   = err_en_q;
      err_sign_d = err_sign_q;
      err_pos_d  = err_pos_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               mcand_d = W_BITS'(bus.N);
               acc_d   = '0;
               cnt_d   = '0;
`ifdef AN_ERR_INJECT_EN
               err_en_d   = bus.err_en;
               err_sign_d = bus.err_sign;
               err_pos_d  = bus.err_pos;
`endif
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            // One bit of the constant per cycle, LSB first.
            if (A_VEC[cnt_q]) begin
               acc_d = acc_q + (mcand_q << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_BITS'(A_BITS - 1)) begin
`ifdef AN_ERR_INJECT_EN
               state_d = ST_INJ;
`else
               state_d = ST_OUT;
`endif
            end
         end
`ifdef AN_ERR_INJECT_EN
         ST_INJ: begin
            acc_d   = inj_acc;
            state_d = ST_OUT;
         end
`endif
         ST_OUT: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef AN_ERR_INJECT_EN
         err_en_q   <= 1'b0;
         err_sign_q <= 1'b0;
         err_pos_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef AN_ERR_INJECT_EN
         err_en_q   <= err_en_d;
         err_sign_q <= err_sign_d;
         err_pos_q  <= err_pos_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_OUT);
   assign bus.W         = acc_q;

endmodule

// File: tb/tb_an_encoder_28bits.sv
// tb/tb_an_encoder_28bits.sv - randomized scoreboard bench for an_encoder_28bits (AN_ERR_INJECT_EN aware)
module tb_an_encoder_28bits;
   import an_code_pkg::*;

`ifdef AN_ERR_INJECT_EN
   localparam int LAT = 16;
`else
   localparam int LAT = 15;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   an_encoder_28bits_if bus ();

   an_encoder_28bits dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   longint      cyc   = 0;
   logic [63:0] exp_q[$];
   longint      acc_cyc_q[$];
   bit          seen_valid = 0;
   bit          rand_ready = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] model(logic [63:0] n, bit en, int pos, bit sgn);
      logic [63:0] w;
      w = 64'(A) * n;
      if (en && pos < W_BITS) w = sgn ? (w - (64'd1 << pos)) : (w + (64'd1 << pos));
      return w & ((64'd1 << W_BITS) - 1);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard: every cycle, compare handshake outputs with the queue of accepted words.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_cyc_q.delete();
         seen_valid = 0;
         check("reset_out_valid", bus.out_valid, 0);
         check("reset_W", bus.W, 0);
      end else begin
         check("in_ready_vs_model", bus.in_ready, exp_q.size() == 0);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_valid_without_word", bus.out_valid, 0);
            end else begin
               check("W_vs_model", bus.W, exp_q[0]);
               if (!seen_valid) check("latency", cyc - acc_cyc_q[0], LAT);
               seen_valid = 1;
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  void'(acc_cyc_q.pop_front());
                  seen_valid = 0;
               end
            end
         end else if (exp_q.size() != 0 && (cyc - acc_cyc_q[0]) >= LAT) begin
            check("out_valid_missing", bus.out_valid, 1);
         end
         if (bus.in_valid && bus.in_ready) begin
`ifdef AN_ERR_INJECT_EN
            exp_q.push_back(model(64'(bus.N), bus.err_en, int'(bus.err_pos), bus.err_sign));
`else
            exp_q.push_back(model(64'(bus.N), 1'b0, 0, 1'b0));
`endif
            acc_cyc_q.push_back(cyc + 1);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(logic [N_BITS-1:0] n, bit en, int pos, bit sgn);
      bit ok;
      ok = 0;
      @(posedge clk) #1;
      bus.in_valid = 1'b1;
      bus.N        = n;
`ifdef AN_ERR_INJECT_EN
      bus.err_en   = en;
      bus.err_pos  = 6'(pos);
      bus.err_sign = sgn;
`endif
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", bus.in_ready, 1);
      @(posedge clk) #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [63:0] w);
      bit ok;
      ok = 0;
      w  = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1;
            w  = 64'(bus.W);
            break;
         end
      end
      if (!ok) check("out_timeout", bus.out_valid, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.out_valid) break;
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic run_lit(string name, logic [N_BITS-1:0] n, bit en, int pos, bit sgn,
                          logic [63:0] expv);
      logic [63:0] w;
      send(n, en, pos, sgn);
      wait_out(w);
      check(name, w, expv);
      drain();
   endtask

   initial begin
      logic [63:0] w0;
      bus.in_valid  = 1'b0;
      bus.N         = '0;
      bus.out_ready = 1'b1;
`ifdef AN_ERR_INJECT_EN
      bus.err_en    = 1'b0;
      bus.err_pos   = '0;
      bus.err_sign  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_W", bus.W, 0);

      run_lit("lit_N0", 28'd0, 0, 0, 0, 64'd0);
      run_lit("lit_N1", 28'd1, 0, 0, 0, 64'd17619);
      run_lit("lit_N1000", 28'd1000, 0, 0, 0, 64'd17619000);
      run_lit("lit_Nmax", 28'd268435455, 0, 0, 0, 64'd4729564281645);

`ifdef AN_ERR_INJECT_EN
      run_lit("inj_pos3_add", 28'd1, 1, 3, 0, 64'd17627);
      run_lit("inj_pos0_sub", 28'd1, 1, 0, 1, 64'd17618);
      run_lit("inj_pos50", 28'd1, 1, 50, 0, 64'd17619);
`endif

      // Backpressure: hold the result, poke in_valid, then release.
      bus.out_ready = 1'b0;
      send(28'd1000, 0, 0, 0);
      wait_out(w0);
      check("bp_first_W", w0, 64'd17619000);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk) #1;
         bus.in_valid = ~bus.in_valid;
         bus.N        = 28'($urandom);
         @(negedge clk);
         check("bp_W_stable", bus.W, 64'd17619000);
         check("bp_in_ready_low", bus.in_ready, 0);
         check("bp_out_valid_high", bus.out_valid, 1);
      end
      @(posedge clk) #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk) #1;
      @(negedge clk);
      check("bp_in_ready_after_hs", bus.in_ready, 1);
      check("bp_out_valid_after_hs", bus.out_valid, 0);
      drain();

      // Reset mid-multiply discards the word in flight.
      send(28'd5, 0, 0, 0);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_W", bus.W, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(posedge clk) #1 rst_n = 1'b1;
      @(negedge clk);
      check("postrst_in_ready", bus.in_ready, 1);
      run_lit("postrst_N2", 28'd2, 0, 0, 0, 64'd35238);

      // Random words with random backpressure and, when built in, random errors.
      rand_ready = 1;
      for (int k = 0; k < 200; k++) begin
         send(28'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 47)),
              1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      rand_ready = 0;
      @(posedge clk) #2;
      bus.out_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
